// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_ctrl opcodes, FSM state encoding and result packing.
// Also imported by the decoder that produces alu_ctrl.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic        err;
    logic        zero;
    logic [31:0] result;
  } alu_out_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_XOR) || is_shift_op(op);
  endfunction

  function automatic alu_out_t make_out(input logic [31:0] r);
    alu_out_t o;
    o.err    = 1'b0;
    o.zero   = (r == 32'd0);
    o.result = r;
    return o;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for alu_exec_unit: iterative 1-bit-per-cycle shifter by default,
// single-cycle barrel shifter when ALU_BARREL_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  output logic        imm_o,
  output logic [31:0] imm_result_o,
  output logic        last_o,
  output logic [31:0] step_result_o
);

`ifdef ALU_BARREL_SHIFT_EN
  logic unused_seq;
  assign unused_seq = &{1'b0, clk, rst, start_i};

  always_comb begin
    imm_result_o = data_i;
    case (op_i)
      ALU_SLL: imm_result_o = data_i << shamt_i;
      ALU_SRL: imm_result_o = data_i >> shamt_i;
      ALU_SRA: imm_result_o = $unsigned($signed(data_i) >>> shamt_i);
      default: imm_result_o = data_i;
    endcase
  end

  assign imm_o         = 1'b1;
  assign last_o        = 1'b0;
  assign step_result_o = 32'd0;
`else
  logic [31:0] sh_q, sh_d;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;

  always_comb begin
    sh_d = sh_q;
    case (op_q)
      ALU_SLL: sh_d = {sh_q[30:0], 1'b0};
      ALU_SRL: sh_d = {1'b0, sh_q[31:1]};
      default: sh_d = {sh_q[31], sh_q[31:1]};
    endcase
  end

  // A zero-amount shift never loads; the top completes it directly from data_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= 32'd0;
      cnt_q <= 5'd0;
      op_q  <= 4'd0;
    end else if (start_i && (shamt_i != 5'd0)) begin
      sh_q  <= data_i;
      cnt_q <= shamt_i;
      op_q  <= op_i;
    end else if (cnt_q != 5'd0) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign imm_o         = (shamt_i == 5'd0);
  assign imm_result_o  = data_i;
  assign last_o        = (cnt_q == 5'd1);
  assign step_result_o = sh_d;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: IDLE/SHIFT/DONE FSM with valid/ready on both sides.
// Shift latency depends on ALU_BARREL_SHIFT_EN (see alu_shifter); results do not.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready
  // (IDLE only); a result transfers on a rising edge with out_valid && out_ready
  // (DONE only). Outputs hold steady while out_valid is high and out_ready low.

  logic [1:0] state_q, state_d;
  alu_out_t   out_q, out_d;
  logic [31:0] alu_val;
  logic        accept;
  logic        sh_imm, sh_last;
  logic [31:0] sh_imm_result, sh_step;

  assign accept = in_valid && in_ready;

  alu_shifter u_shifter (
    .clk           (clk),
    .rst           (rst),
    .start_i       (accept && is_shift_op(alu_ctrl)),
    .op_i          (alu_ctrl),
    .data_i        (op_a),
    .shamt_i       (op_b[4:0]),
    .imm_o         (sh_imm),
    .imm_result_o  (sh_imm_result),
    .last_o        (sh_last),
    .step_result_o (sh_step)
  );

  always_comb begin
    alu_val = 32'd0;
    case (alu_ctrl)
      ALU_AND: alu_val = op_a & op_b;
      ALU_OR:  alu_val = op_a | op_b;
      ALU_ADD: alu_val = op_a + op_b;
      ALU_SUB: alu_val = op_a - op_b;
      ALU_XOR: alu_val = op_a ^ op_b;
      default: alu_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_legal_op(alu_ctrl)) begin
            out_d   = '{err: 1'b1, zero: 1'b1, result: 32'd0};
            state_d = ST_DONE;
          end else if (is_shift_op(alu_ctrl)) begin
            if (sh_imm) begin
              out_d   = make_out(sh_imm_result);
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            out_d   = make_out(alu_val);
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          out_d   = make_out(sh_step);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = out_q.result;
  assign zero        = out_q.zero;
  assign err         = out_q.err;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random bench for alu_exec_unit with an expected-result queue.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  alu_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {err, zero, result}
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    logic [4:0]  s;
    e = 1'b0;
    s = b[4:0];
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1000: r = a ^ b;
      4'b0011: r = a << s;
      4'b1010: r = a >> s;
      4'b1011: r = $unsigned($signed(a) >>> s);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, (r == 32'd0), r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    int lat;
    lat = 1;
`ifndef ALU_BARREL_SHIFT_EN
    if ((op == 4'b0011 || op == 4'b1010 || op == 4'b1011) && b[4:0] != 5'd0)
      lat = int'(b[4:0]) + 1;
`endif
    return lat;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    alu_ctrl = op;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(op, a, b));
    drive(op, a, b);
  endtask

  task automatic collect(input string tag, input int lat, input int stall);
    int cyc;
    logic [33:0] exp;
    logic [33:0] held;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    if (out_valid && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_out"}, {30'd0, err, zero, result}, {30'd0, exp});
      held = {err, zero, result};
      for (int i = 0; i < stall; i++) begin
        // a request offered while busy must be ignored
        in_valid = 1'b1;
        alu_ctrl = ALU_ADD;
        op_a     = $urandom();
        op_b     = $urandom();
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_hold_out"}, {30'd0, err, zero, result}, {30'd0, held});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_release_valid"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_release_ready"}, {63'd0, in_ready}, 64'd1);
    end
  endtask

  initial begin : main
    logic [3:0] ops[8];
    logic [3:0] op;
    logic [31:0] a, b;
    int stall;
    logic seen;
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_SRL, ALU_SRA};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out", {30'd0, err, zero, result}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    collect("add_ovf", 1, 0);

    issue(ALU_SUB, 32'd5, 32'd5);
    collect("sub_zero", 1, 3);

    issue(ALU_SRA, 32'h8000_0000, 32'd4);
    collect("sra4", exp_lat(ALU_SRA, 32'd4), 0);

    issue(ALU_SLL, 32'h1234_5678, 32'd0);
    collect("sll0", 1, 0);

    issue(ALU_SLL, 32'h0000_0001, 32'h0000_0025);
    collect("sll5", exp_lat(ALU_SLL, 32'h25), 1);

    issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
    collect("illegal_f", 1, 0);

    issue(4'b0100, 32'hFFFF_FFFF, 32'h0000_0003);
    collect("illegal_4", 1, 0);

    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    collect("and", 1, 0);
    issue(ALU_OR, 32'h0F0F_0000, 32'h0000_F0F0);
    collect("or", 1, 0);
    issue(ALU_XOR, 32'hAAAA_5555, 32'hAAAA_5555);
    collect("xor_zero", 1, 0);
    issue(ALU_SUB, 32'd0, 32'd1);
    collect("sub_wrap", 1, 0);
    issue(ALU_SRL, 32'hFFFF_FFFF, 32'd31);
    collect("srl31", exp_lat(ALU_SRL, 32'd31), 0);
    issue(ALU_SRA, 32'h4000_0000, 32'd30);
    collect("sra_pos", exp_lat(ALU_SRA, 32'd30), 0);

    // reset in the middle of a long shift: no result may appear
    drive(ALU_SRL, 32'hFFFF_FFFF, 32'd31);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_valid_in_rst", {63'd0, out_valid}, 64'd0);
    check("abort_state_in_rst", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", {63'd0, seen}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      op    = ops[$urandom_range(0, 7)];
      a     = $urandom();
      b     = $urandom();
      stall = $urandom_range(0, 2);
      issue(op, a, b);
      collect("rand", exp_lat(op, b), stall);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
